hex_display_driver: RTL and testbench



---
 rtl/hex_display_driver.sv | 189 ++++++++++++++++++
 tb/tb_hex_display_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: 0-F glyphs, per-digit decimal point and blink,
// optional leading-zero blanking. Offers a parallel segment bus (one group per
// digit) and a time-multiplexed scan bus. Loads are double-buffered and only
// committed when the scan wraps from the last digit back to digit 0, so a frame
// never shows a mix of old and new digits.
//
// Handshake: load is a one-cycle strobe with no back-pressure. busy is high
// from the edge after a load until the frame-boundary commit that consumes it;
// a load while busy simply replaces the pending data.
module hex_display_driver #(
    parameter int DIGITS     = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lzb,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   seg_all,
    output logic [DIGITS-1:0]     dp_all,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int   PRE_W = $clog2(SCAN_DIV);
    localparam int   BLK_W = $clog2(BLINK_DIV);
    localparam logic POL   = (ACTIVE_LOW != 0);

    // Active-high glyph for one hex nibble, bit 0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [4*DIGITS-1:0] r_pend_value;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_blink;
    logic [4*DIGITS-1:0] r_act_value;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blink;
    logic                r_busy;
    logic [PRE_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_blink_phase;
    logic [7*DIGITS-1:0] r_seg_all;
    logic [DIGITS-1:0]   r_dp_all;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_tick;
    logic                w_wrap;
    logic                w_commit;
    logic [7*DIGITS-1:0] w_seg_vec;
    logic [DIGITS-1:0]   w_dp_vec;
    logic [6:0]          w_seg_scan;
    logic                w_dp_scan;
    logic [DIGITS-1:0]   w_an_onehot;

    assign w_tick   = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_wrap   = w_tick && (r_scan_idx == IDX_W'(DIGITS - 1));
    assign w_commit = w_wrap && r_busy;

    // Render every digit active-high from the committed state, applying
    // leading-zero blanking (top digit downward) and the blink phase.
    always_comb begin : render
        logic       w_above_nz;
        logic       w_lz_blank;
        logic       w_blink_blank;
        logic [3:0] w_nib;
        w_seg_vec  = '0;
        w_dp_vec   = '0;
        w_above_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nib = r_act_value[4*i +: 4];
            if (w_nib != 4'h0) begin
                w_above_nz = 1'b1;
            end
            w_lz_blank    = lzb && !w_above_nz && (i != 0);
            w_blink_blank = r_blink_phase && r_act_blink[i];
            w_seg_vec[7*i +: 7] = (w_lz_blank || w_blink_blank) ? 7'h00 : glyph(w_nib);
            w_dp_vec[i]         = r_act_dp[i] && !w_blink_blank;
        end
    end

    // Select the digit at the current scan index for the multiplexed bus.
    always_comb begin
        w_seg_scan  = 7'h00;
        w_dp_scan   = 1'b0;
        w_an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == IDX_W'(i)) begin
                w_seg_scan     = w_seg_vec[7*i +: 7];
                w_dp_scan      = w_dp_vec[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    // Capture loads into the pending buffer and commit it at the frame boundary.
    // On a coincident load and commit the commit takes the old pending data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (w_commit) begin
                r_act_value <= r_pend_value;
                r_act_dp    <= r_pend_dp;
                r_act_blink <= r_pend_blink;
            end
            if (load) begin
                r_pend_value <= value;
                r_pend_dp    <= dp_in;
                r_pend_blink <= blink_in;
                r_busy       <= 1'b1;
            end else if (w_commit) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Scan prescaler, scan index and blink timebase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_scan_idx    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc    <= '0;
                r_scan_idx <= w_wrap ? '0 : r_scan_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
            if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    // Register both output buses with the selected polarity; blank during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_all <= {(7*DIGITS){POL}};
            r_dp_all  <= {DIGITS{POL}};
            r_seg     <= {7{POL}};
            r_dp      <= POL;
            r_an      <= {DIGITS{POL}};
        end else begin
            r_seg_all <= w_seg_vec ^ {(7*DIGITS){POL}};
            r_dp_all  <= w_dp_vec ^ {DIGITS{POL}};
            r_seg     <= w_seg_scan ^ {7{POL}};
            r_dp      <= w_dp_scan ^ POL;
            r_an      <= w_an_onehot ^ {DIGITS{POL}};
        end
    end

    assign busy    = r_busy;
    assign seg_all = r_seg_all;
    assign dp_all  = r_dp_all;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign an      = r_an;

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

  localparam int W = 45;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blink_in;
  logic        lzb;
  logic        busy;
  logic [27:0] seg_all;
  logic [3:0]  dp_all;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  logic        load2;
  logic [3:0]  value2;
  logic [0:0]  dp2_in;
  logic [0:0]  blink2_in;
  logic        lzb2;
  logic        busy2;
  logic [6:0]  seg_all2;
  logic [0:0]  dp_all2;
  logic [6:0]  seg2;
  logic        dp2;
  logic [0:0]  an2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state: cycles since reset release, pending and displayed data
  int          m_t = 0;
  logic [15:0] m_pend_v = '0, m_act_v = '0;
  logic [3:0]  m_pend_d = '0, m_act_d = '0;
  logic [3:0]  m_pend_b = '0, m_act_b = '0;
  logic        m_busy = 1'b0;

  hex_display_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blink_in(blink_in), .lzb(lzb), .busy(busy), .seg_all(seg_all),
    .dp_all(dp_all), .seg(seg), .dp(dp), .an(an)
  );

  hex_display_driver #(.DIGITS(1), .SCAN_DIV(2), .BLINK_DIV(2), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value(value2), .dp_in(dp2_in),
    .blink_in(blink2_in), .lzb(lzb2), .busy(busy2), .seg_all(seg_all2),
    .dp_all(dp_all2), .seg(seg2), .dp(dp2), .an(an2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Display of a whole word: {dp_all, seg_all}, active-high.
  function automatic logic [31:0] render_all(input logic [15:0] v, input logic [3:0] d,
                                             input logic [3:0] b, input logic lz, input logic ph);
    logic [31:0] r;
    logic        blink_off;
    logic        lz_off;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      blink_off = ph && b[i];
      lz_off    = lz && (i != 0) && ((v >> (4 * i)) == 16'd0);
      r[7*i +: 7] = (blink_off || lz_off) ? 7'h00 : glyph_tbl[v[4*i +: 4]];
      r[28 + i]   = d[i] && !blink_off;
    end
    return r;
  endfunction

  task automatic model_step();
    logic [W-1:0] e;
    logic [31:0]  rend;
    int           idx;
    logic         ph;
    if (!rst_n) begin
      m_t = 0;
      m_pend_v = '0; m_pend_d = '0; m_pend_b = '0;
      m_act_v  = '0; m_act_d  = '0; m_act_b  = '0;
      m_busy = 1'b0;
      e = '0;
    end else begin
      idx  = (m_t / 4) % 4;
      ph   = ((m_t / 16) % 2) == 1;
      rend = render_all(m_act_v, m_act_d, m_act_b, lzb, ph);
      if ((m_t % 16) == 15 && m_busy) begin
        m_act_v = m_pend_v; m_act_d = m_pend_d; m_act_b = m_pend_b;
        m_busy  = 1'b0;
      end
      if (load) begin
        m_pend_v = value; m_pend_d = dp_in; m_pend_b = blink_in;
        m_busy   = 1'b1;
      end
      m_t++;
      e = {m_busy, 4'(1 << idx), rend[28 + idx], rend[7*idx +: 7], rend[31:28], rend[27:0]};
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {busy, an, dp, seg, dp_all, seg_all};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got {busy,an,dp,seg,dp_all,seg_all}=%h expected %h",
                   $time, a, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load = 1'b1; value = v; dp_in = d; blink_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  // wait (bounded) until the next edge is the given frame phase
  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((m_t % 16) != ph && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ((m_t % 16) != ph) begin
      n_bad++;
      $display("FAIL wait_phase: got phase %0d expected %0d", m_t % 16, ph);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blink_in = '0; lzb = 1'b0;
    load2 = 1'b0; value2 = '0; dp2_in = '0; blink2_in = '0; lzb2 = 1'b0;

    idle(2);
    // active-low single-digit instance under reset: all off, anode inactive
    check("al_reset_seg_all", 16'(seg_all2), 16'h007F);
    check("al_reset_an", 16'(an2), 16'h0001);
    check("al_reset_dp_all", 16'(dp_all2), 16'h0001);
    idle(1);
    rst_n = 1'b1;

    // reset then idle: 0000 shown, an walks through all digits
    idle(20);

    // mid-frame load
    do_load(16'h12AF, 4'h0, 4'h0);
    idle(20);

    // two loads in one frame, then one on the exact commit cycle
    wait_phase(2);
    do_load(16'h1111, 4'h0, 4'h0);
    idle(2);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_phase(15);
    do_load(16'h3333, 4'h0, 4'h0);
    idle(36);

    // leading-zero blanking
    lzb = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0);
    idle(20);
    do_load(16'h0000, 4'h0, 4'h0);
    idle(20);
    lzb = 1'b0;

    // blink on digits 0 and 2, dp on all
    do_load(16'h8765, 4'hF, 4'h5);
    idle(70);

    // active-low instance: commit of 1 shows inverse of glyph 1
    load2 = 1'b1; value2 = 4'h1;
    @(negedge clk);
    load2 = 1'b0;
    idle(6);
    check("al_seg_all_1", 16'(seg_all2), 16'h0079);
    check("al_seg_1", 16'(seg2), 16'h0079);
    check("al_an_1", 16'(an2), 16'h0000);
    check("al_busy_1", 16'(busy2), 16'h0000);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 5) == 0)
        do_load(16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3))),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        idle(1);
    end

    // mid-operation reset discards pending data
    lzb = 1'b0;
    idle(20);
    do_load(16'hBEEF, 4'h3, 4'h0);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(24);

    @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
